exe_stage_md: RTL and testbench
===============================

Name: exe_stage_md

Overview:
- Parametrised execute stage for the RISC-V-lite pipeline. Sits between the ID/EX and EX/MEM boundaries.
- Adds the following:
  - forwarded-operand branch resolution with signed and unsigned compares;
  - JALR target generation;
  - a registered redirect;
  - an iterative multi-cycle RV32M multiply/divide unit that stalls the front end while busy.
- Owns the EX/MEM pipeline registers.

Parameters:
- XLEN, 32, datapath width.
- RD_W, 5, destination register index width.
- CW_MEM_W, 7, width of the control word forwarded to MEM/WB.
- ALU_OP_W, 4, width of the op code for the existing ALU.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- pipe_en  in  1  EX/MEM register load enable from the hazard unit.
- flush  in  1  kill the instruction in EX; abort the mul/div.
- in_valid  in  1  ID/EX holds a real instruction.
- op_a_sel  in  1  0=npc, 1=r1.
- op_b_sel  in  1  0=r2, 1=imm.
- alu_op  in  ALU_OP_W  ALU function.
- md_en  in  1  instruction is RV32M.
- md_op  in  3  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (package enum).
- br_type  in  3  000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU.
- jal  in  1  JAL.
- jalr  in  1  JALR.
- npc  in  XLEN  PC of the instruction.
- npc4  in  XLEN  PC+4.
- r1  in  XLEN  RF operand.
- r2  in  XLEN  RF operand.
- imm  in  XLEN  sign-extended byte offset/immediate.
- fwd_a  in  2  00 rf, 01 MEM/WB, 10 EX/MEM.
- fwd_b  in  2  00 rf, 01 MEM/WB, 10 EX/MEM.
- memwb_val  in  XLEN  forward source.
- exmem_val  in  XLEN  forward source.
- rd_in  in  RD_W  destination index.
- cw_mem_in  in  CW_MEM_W  downstream control word.
- stall_o  out  1  freeze PC/IF/ID/ID-EX (combinational).
- alu_res  out  XLEN  registered result.
- b_out  out  XLEN  registered forwarded rs2 (store data).
- npc4_out  out  XLEN  registered.
- rd_out  out  RD_W  registered.
- cw_mem  out  CW_MEM_W  registered.
- pc_sel  out  1  registered redirect.
- jpc  out  XLEN  registered redirect target.

Behaviour:
- Reset: every output register clears to 0 asynchronously on rst=0. FSM goes to IDLE; counter clears to 0.
- Operand forwarding:
  - fa/fb are the forwarded r1/r2 selected by fwd_a/fwd_b; code 11 selects the rf value.
  - ALU A = op_a_sel ? fa : npc. ALU B = op_b_sel ? imm : fb.
- Branch resolution:
  - Compares fa against fb: signed for BLT/BGE, unsigned for BLTU/BGEU. Encodings 111/000 give no branch.
  - Target is npc+imm for branches and JAL, and (fa+imm) with bit0 cleared for JALR. Arithmetic is modulo 2^XLEN.
  - take = in_valid & !flush & (jal | jalr | branch_true).
- EX/MEM registers load only when pipe_en=1 and stall_o=0.
  - If pipe_en=1 and stall_o=1, load a bubble: cw_mem=0, pc_sel=0, rd_out=0; data registers are don't-care.
  - If flush=1 or in_valid=0, load the same bubble.
- Mul/div FSM:
  - States are IDLE, BUSY, DONE.
  - IDLE -> BUSY when in_valid & md_en & !flush. stall_o=1 combinationally in that cycle.
  - BUSY runs exactly XLEN iterations (1 bit/cycle: shift-add multiply, restoring divide) with stall_o=1.
  - After the last iteration the FSM moves to DONE. In DONE, stall_o=0, alu_res captures the md result, and the FSM returns to IDLE on the load edge.
  - Issue-to-EX/MEM latency is XLEN+2 edges; stall_o is high for XLEN+1 cycles.
  - In DONE with pipe_en=0, the FSM holds DONE until pipe_en=1.
- Operand capture: signs and magnitudes are latched at issue, so later forwarding changes are ignored.
- Special cases:
  - Divide by zero: quotient all-ones; remainder = dividend.
  - Signed overflow (min / -1): quotient = min; remainder 0.
  - MULH, MULHSU and MULHU return the upper XLEN bits of the 2·XLEN-bit product.
- flush in BUSY or DONE aborts to IDLE next edge, with no EX/MEM write. stall_o follows the state: 0 in IDLE unless a new issue is presented.
- Reset mid-operation aborts immediately to IDLE.
- While busy, br_type and jal are don't-care: md instructions never redirect.

Optional Feature:
- EXE_MULDIV_EN.
  - Defined: the mul/div unit and FSM are instantiated as above.
  - Undefined: md_en is ignored, stall_o is tied 0, and an md instruction is executed by the ALU as plain alu_op. There is no multi-cycle logic.

Decomposition:
- Package exe_pkg holds:
  - md_op_e and br_type_e enums;
  - fwd_sel_e;
  - md_state_e;
  - localparams for the bubble control word (all-zero) and for the JALR LSB mask.
- Sub-module md_unit (XLEN) owns:
  - the iterative multiply/divide with start/abort/busy/done handshake;
  - the iteration counter sized $clog2(XLEN+1);
  - sign fix-up and the zero/overflow cases.
- The existing ALU and register_generic are reused.

Test Plan:
- BLT with fa=0xFFFF_FFFF, fb=1 -> pc_sel=1, jpc=npc+imm. BLTU with the same operands -> pc_sel=0.
- JALR with fa=0x1001, imm=4, fwd_a=10 (exmem_val=0x1001) -> jpc=0x1004 (LSB cleared), pc_sel=1.
- MUL 7×-3 -> stall_o high 33 cycles, alu_res=0xFFFF_FFEB at edge 34. MULHU 0xFFFF_FFFF² -> 0xFFFF_FFFE.
- DIV 0x8000_0000 / -1 -> 0x8000_0000. REM -> 0. DIVU 5/0 -> 0xFFFF_FFFF. REMU 5/0 -> 5.
- flush asserted mid-BUSY (iteration 10) -> stall_o=0 next cycle, cw_mem=0, FSM IDLE. A following ADD completes in 1 cycle.
- rst=0 asynchronously during BUSY -> all outputs 0 immediately. pipe_en=0 in DONE -> result held until pipe_en=1.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared types and constants for the execute stage and its mul/div unit.
package exe_pkg;

    typedef enum logic [2:0] {
        MdMul    = 3'd0,
        MdMulh   = 3'd1,
        MdMulhsu = 3'd2,
        MdMulhu  = 3'd3,
        MdDiv    = 3'd4,
        MdDivu   = 3'd5,
        MdRem    = 3'd6,
        MdRemu   = 3'd7
    } md_op_e;

    typedef enum logic [2:0] {
        BrNone = 3'd0,
        BrEq   = 3'd1,
        BrNe   = 3'd2,
        BrLt   = 3'd3,
        BrGe   = 3'd4,
        BrLtu  = 3'd5,
        BrGeu  = 3'd6,
        BrRsvd = 3'd7
    } br_type_e;

    typedef enum logic [1:0] {
        FwdRf    = 2'd0,
        FwdMemWb = 2'd1,
        FwdExMem = 2'd2,
        FwdRfAlt = 2'd3
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MdIdle = 2'd0,
        MdBusy = 2'd1,
        MdDone = 2'd2
    } md_state_e;

    // Function codes of the pre-existing ALU.
    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluPassB = 4'd10
    } alu_op_e;

    // Control word loaded into EX/MEM for a bubble.
    localparam int unsigned CW_BUBBLE = 0;
    // JALR targets always have bit 0 cleared.
    localparam logic [63:0] JALR_MASK = ~64'd1;

endpackage

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide: one bit per cycle, shift-add multiply and
// restoring divide on magnitudes, with sign fix-up applied to the final result.
// Only compiled when EXE_MULDIV_EN is defined.
`ifdef EXE_MULDIV_EN
module md_unit
    import exe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            ack,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            idle,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] res
);

    localparam int unsigned CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    md_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;    // product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;      // multiplier -> product low / dividend -> quotient
    logic [XLEN-1:0] opb_q, opb_d;    // multiplicand / divisor magnitude
    md_op_e          op_q, op_d;
    logic            negq_q, negq_d;  // negate product or quotient
    logic            negr_q, negr_d;  // negate remainder

    logic            a_signed, b_signed, a_neg, b_neg, b_zero;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   mul_sum, rem_sh;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] quo, rem;

    assign idle = (state_q == MdIdle);
    assign busy = (state_q == MdBusy);
    assign done = (state_q == MdDone);

    // Operand signs and magnitudes as seen at issue.
    always_comb begin
        a_signed = (op == MdMulh) || (op == MdMulhsu) || (op == MdDiv) || (op == MdRem);
        b_signed = (op == MdMulh) || (op == MdDiv) || (op == MdRem);
        a_neg    = a_signed & a[XLEN-1];
        b_neg    = b_signed & b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        b_zero   = (b == '0);
    end

    // FSM next state and one iteration of the datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        op_d    = op_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        rem_sh  = {acc_q, lo_q[XLEN-1]};
        unique case (state_q)
            MdIdle: begin
                if (start && !abort) begin
                    state_d = MdBusy;
                    cnt_d   = '0;
                    acc_d   = '0;
                    lo_d    = a_mag;
                    opb_d   = b_mag;
                    op_d    = md_op_e'(op);
                    // Divide by zero: the raw all-ones quotient must stay unsigned;
                    // the remainder naturally comes back as the dividend.
                    // min / -1 needs no special case: |min| / 1 = min after wrap.
                    negq_d  = (a_neg ^ b_neg) & ~(op[2] & b_zero);
                    negr_d  = a_neg;
                end
            end
            MdBusy: begin
                if (abort) begin
                    state_d = MdIdle;
                end else begin
                    if (op_q[2]) begin
                        if (rem_sh >= {1'b0, opb_q}) begin
                            acc_d = XLEN'(rem_sh - {1'b0, opb_q});
                            lo_d  = {lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            acc_d = rem_sh[XLEN-1:0];
                            lo_d  = {lo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = mul_sum[XLEN:1];
                        lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                    if (cnt_q == LAST_ITER) begin
                        state_d = MdDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            MdDone: begin
                if (abort || ack) begin
                    state_d = MdIdle;
                end
            end
            default: state_d = MdIdle;
        endcase
    end

    // Final sign fix-up and result selection.
    always_comb begin
        prod     = {acc_q, lo_q};
        prod_fix = negq_q ? -prod : prod;
        quo      = negq_q ? -lo_q : lo_q;
        rem      = negr_q ? -acc_q : acc_q;
        unique case (op_q)
            MdMul:                     res = prod_fix[XLEN-1:0];
            MdMulh, MdMulhsu, MdMulhu: res = prod_fix[2*XLEN-1:XLEN];
            MdDiv, MdDivu:             res = quo;
            default:                   res = rem;
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MdIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            op_q    <= MdMul;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

endmodule
`endif

// File: rtl/exe_stage_md.sv
// Execute stage: operand forwarding, ALU, branch/JALR resolution, registered
// redirect and the EX/MEM pipeline registers. Define EXE_MULDIV_EN to add the
// iterative RV32M unit, which stalls the front end while it works.
module exe_stage_md
    import exe_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned RD_W     = 5,
    parameter int unsigned CW_MEM_W = 7,
    parameter int unsigned ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pipe_en,
    input  logic                flush,
    input  logic                in_valid,
    input  logic                op_a_sel,
    input  logic                op_b_sel,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic                md_en,
    input  logic [2:0]          md_op,
    input  logic [2:0]          br_type,
    input  logic                jal,
    input  logic                jalr,
    input  logic [XLEN-1:0]     npc,
    input  logic [XLEN-1:0]     npc4,
    input  logic [XLEN-1:0]     r1,
    input  logic [XLEN-1:0]     r2,
    input  logic [XLEN-1:0]     imm,
    input  logic [1:0]          fwd_a,
    input  logic [1:0]          fwd_b,
    input  logic [XLEN-1:0]     memwb_val,
    input  logic [XLEN-1:0]     exmem_val,
    input  logic [RD_W-1:0]     rd_in,
    input  logic [CW_MEM_W-1:0] cw_mem_in,
    output logic                stall_o,
    output logic [XLEN-1:0]     alu_res,
    output logic [XLEN-1:0]     b_out,
    output logic [XLEN-1:0]     npc4_out,
    output logic [RD_W-1:0]     rd_out,
    output logic [CW_MEM_W-1:0] cw_mem,
    output logic                pc_sel,
    output logic [XLEN-1:0]     jpc
);

    localparam int unsigned SH_W = $clog2(XLEN);

    logic [XLEN-1:0] fa, fb, alu_a, alu_b, alu_out, target, ex_res;
    logic [SH_W-1:0] shamt;
    logic            eq, lt_s, lt_u, br_true, take, redirect;

    logic [XLEN-1:0]     alu_res_q, alu_res_d, b_out_q, b_out_d;
    logic [XLEN-1:0]     npc4_out_q, npc4_out_d, jpc_q, jpc_d;
    logic [RD_W-1:0]     rd_out_q, rd_out_d;
    logic [CW_MEM_W-1:0] cw_mem_q, cw_mem_d;
    logic                pc_sel_q, pc_sel_d;

    // Forwarding muxes; code 11 falls back to the register file.
    always_comb begin
        case (fwd_a)
            FwdMemWb: fa = memwb_val;
            FwdExMem: fa = exmem_val;
            default:  fa = r1;
        endcase
        case (fwd_b)
            FwdMemWb: fb = memwb_val;
            FwdExMem: fb = exmem_val;
            default:  fb = r2;
        endcase
    end

    // ALU.
    always_comb begin
        alu_a = op_a_sel ? fa : npc;
        alu_b = op_b_sel ? imm : fb;
        shamt = alu_b[SH_W-1:0];
        case (alu_op)
            AluSub:   alu_out = alu_a - alu_b;
            AluSll:   alu_out = alu_a << shamt;
            AluSlt:   alu_out = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            AluSltu:  alu_out = {{(XLEN-1){1'b0}}, alu_a < alu_b};
            AluXor:   alu_out = alu_a ^ alu_b;
            AluSrl:   alu_out = alu_a >> shamt;
            AluSra:   alu_out = $signed(alu_a) >>> shamt;
            AluOr:    alu_out = alu_a | alu_b;
            AluAnd:   alu_out = alu_a & alu_b;
            AluPassB: alu_out = alu_b;
            default:  alu_out = alu_a + alu_b;
        endcase
    end

    // Branch condition and redirect target.
    always_comb begin
        eq   = (fa == fb);
        lt_s = $signed(fa) < $signed(fb);
        lt_u = fa < fb;
        case (br_type)
            BrEq:    br_true = eq;
            BrNe:    br_true = ~eq;
            BrLt:    br_true = lt_s;
            BrGe:    br_true = ~lt_s;
            BrLtu:   br_true = lt_u;
            BrGeu:   br_true = ~lt_u;
            default: br_true = 1'b0;
        endcase
        take   = in_valid & ~flush & (jal | jalr | br_true);
        target = jalr ? ((fa + imm) & JALR_MASK[XLEN-1:0]) : (npc + imm);
    end

`ifdef EXE_MULDIV_EN
    logic            md_start, md_idle, md_busy, md_done;
    logic [XLEN-1:0] md_res;

    assign md_start = in_valid & md_en & ~flush & md_idle;

    md_unit #(
        .XLEN(XLEN)
    ) u_md_unit (
        .clk  (clk),
        .rst  (rst),
        .start(md_start),
        .abort(flush),
        .ack  (pipe_en),
        .op   (md_op),
        .a    (fa),
        .b    (fb),
        .idle (md_idle),
        .busy (md_busy),
        .done (md_done),
        .res  (md_res)
    );

    assign stall_o  = md_start | md_busy;
    assign ex_res   = md_done ? md_res : alu_out;
    assign redirect = take & ~md_en;
`else
    logic unused_md;
    assign unused_md = md_en ^ (^md_op);
    assign stall_o   = 1'b0;
    assign ex_res    = alu_out;
    assign redirect  = take;
`endif

    // EX/MEM next state: hold, bubble, or the real instruction.
    always_comb begin
        alu_res_d  = alu_res_q;
        b_out_d    = b_out_q;
        npc4_out_d = npc4_out_q;
        jpc_d      = jpc_q;
        rd_out_d   = rd_out_q;
        cw_mem_d   = cw_mem_q;
        pc_sel_d   = pc_sel_q;
        if (pipe_en) begin
            alu_res_d  = ex_res;
            b_out_d    = fb;
            npc4_out_d = npc4;
            jpc_d      = target;
            if (stall_o || flush || !in_valid) begin
                cw_mem_d = CW_MEM_W'(CW_BUBBLE);
                rd_out_d = '0;
                pc_sel_d = 1'b0;
            end else begin
                cw_mem_d = cw_mem_in;
                rd_out_d = rd_in;
                pc_sel_d = redirect;
            end
        end
    end

    // EX/MEM registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_res_q  <= '0;
            b_out_q    <= '0;
            npc4_out_q <= '0;
            jpc_q      <= '0;
            rd_out_q   <= '0;
            cw_mem_q   <= '0;
            pc_sel_q   <= 1'b0;
        end else begin
            alu_res_q  <= alu_res_d;
            b_out_q    <= b_out_d;
            npc4_out_q <= npc4_out_d;
            jpc_q      <= jpc_d;
            rd_out_q   <= rd_out_d;
            cw_mem_q   <= cw_mem_d;
            pc_sel_q   <= pc_sel_d;
        end
    end

    assign alu_res  = alu_res_q;
    assign b_out    = b_out_q;
    assign npc4_out = npc4_out_q;
    assign jpc      = jpc_q;
    assign rd_out   = rd_out_q;
    assign cw_mem   = cw_mem_q;
    assign pc_sel   = pc_sel_q;

endmodule

// File: tb/tb_exe_stage_md.sv
// Directed bench for exe_stage_md; mul/div cases are built only with EXE_MULDIV_EN.
module tb_exe_stage_md;
    import exe_pkg::*;

    logic        clk, rst, pipe_en, flush, in_valid, op_a_sel, op_b_sel;
    logic [3:0]  alu_op;
    logic        md_en, jal, jalr;
    logic [2:0]  md_op, br_type;
    logic [31:0] npc, npc4, r1, r2, imm, memwb_val, exmem_val;
    logic [1:0]  fwd_a, fwd_b;
    logic [4:0]  rd_in, rd_out;
    logic [6:0]  cw_mem_in, cw_mem;
    logic        stall_o, pc_sel;
    logic [31:0] alu_res, b_out, npc4_out, jpc;

    int checks   = 0;
    int failures = 0;

    exe_stage_md #(
        .XLEN(32), .RD_W(5), .CW_MEM_W(7), .ALU_OP_W(4)
    ) dut (
        .clk(clk), .rst(rst), .pipe_en(pipe_en), .flush(flush), .in_valid(in_valid),
        .op_a_sel(op_a_sel), .op_b_sel(op_b_sel), .alu_op(alu_op), .md_en(md_en),
        .md_op(md_op), .br_type(br_type), .jal(jal), .jalr(jalr), .npc(npc), .npc4(npc4),
        .r1(r1), .r2(r2), .imm(imm), .fwd_a(fwd_a), .fwd_b(fwd_b), .memwb_val(memwb_val),
        .exmem_val(exmem_val), .rd_in(rd_in), .cw_mem_in(cw_mem_in), .stall_o(stall_o),
        .alu_res(alu_res), .b_out(b_out), .npc4_out(npc4_out), .rd_out(rd_out),
        .cw_mem(cw_mem), .pc_sel(pc_sel), .jpc(jpc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; flush = 0; op_a_sel = 0; op_b_sel = 0; alu_op = 0; md_en = 0;
        md_op = 0; br_type = 0; jal = 0; jalr = 0; npc = 0; npc4 = 0; r1 = 0; r2 = 0;
        imm = 0; fwd_a = 0; fwd_b = 0; memwb_val = 0; exmem_val = 0; rd_in = 0;
        cw_mem_in = 0;
    endtask

    task automatic alu_instr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input logic [6:0] cw);
        clear_inputs();
        in_valid = 1; op_a_sel = 1; op_b_sel = 0; alu_op = op; r1 = a; r2 = b;
        rd_in = rd; cw_mem_in = cw;
    endtask

    typedef struct packed {
        logic [2:0]  bt;
        logic [31:0] a;
        logic [31:0] b;
        logic        take;
    } br_vec_t;

    br_vec_t br_tab [9] = '{
        '{3'd3, 32'hFFFF_FFFF, 32'd1, 1'b1},  // BLT  -1 < 1
        '{3'd5, 32'hFFFF_FFFF, 32'd1, 1'b0},  // BLTU big < 1
        '{3'd4, 32'hFFFF_FFFF, 32'd1, 1'b0},  // BGE
        '{3'd6, 32'hFFFF_FFFF, 32'd1, 1'b1},  // BGEU
        '{3'd1, 32'd5, 32'd5, 1'b1},          // BEQ
        '{3'd2, 32'd5, 32'd5, 1'b0},          // BNE equal
        '{3'd2, 32'd5, 32'd6, 1'b1},          // BNE differ
        '{3'd7, 32'd5, 32'd5, 1'b0},          // reserved
        '{3'd0, 32'd5, 32'd5, 1'b0}           // none
    };

`ifdef EXE_MULDIV_EN
    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } md_vec_t;

    md_vec_t md_tab [15] = '{
        '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},  // MUL 7*-3
        '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},  // MULHU
        '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},  // MULH -1*-1
        '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},  // MULHSU
        '{3'd0, 32'h1234_5678, 32'h10,        32'h2345_6780},  // MUL
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},  // DIV overflow
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},  // REM overflow
        '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF},  // DIVU /0
        '{3'd7, 32'd5,          32'd0,         32'd5},          // REMU /0
        '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD},  // DIV -7/2
        '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF},  // REM -7%2
        '{3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF},  // DIV -7/0
        '{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9},  // REM -7%0
        '{3'd5, 32'd100,        32'd7,         32'd14},         // DIVU
        '{3'd7, 32'd100,        32'd7,         32'd2}           // REMU
    };

    task automatic md_issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        clear_inputs();
        in_valid = 1; md_en = 1; md_op = op; r1 = a; r2 = b; op_a_sel = 1;
        rd_in = 5'd7; cw_mem_in = 7'h33;
    endtask

    // Counts cycles with stall_o high, starting from the issue cycle.
    task automatic md_wait(output int n);
        n = 0;
        #1;
        while (stall_o && n < 100) begin
            n++;
            step();
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1; pipe_en = 1;
        clear_inputs();
        #2 rst = 0;
        repeat (2) step();
        check_eq("rst_alu_res", alu_res, 0);
        check_eq("rst_cw_mem", {25'd0, cw_mem}, 0);
        check_eq("rst_rd_out", {27'd0, rd_out}, 0);
        check_eq("rst_pc_sel", {31'd0, pc_sel}, 0);
        check_eq("rst_jpc", jpc, 0);
        check_eq("rst_stall", {31'd0, stall_o}, 0);
        rst = 1;

        // Branch table.
        for (int i = 0; i < 9; i++) begin
            clear_inputs();
            in_valid = 1; br_type = br_tab[i].bt; r1 = br_tab[i].a; r2 = br_tab[i].b;
            npc = 32'h100; npc4 = 32'h104; imm = 32'h20;
            step();
            check_eq($sformatf("br%0d_pc_sel", i), {31'd0, pc_sel}, {31'd0, br_tab[i].take});
            if (br_tab[i].take) check_eq($sformatf("br%0d_jpc", i), jpc, 32'h120);
        end

        // JALR with EX/MEM forwarding.
        clear_inputs();
        in_valid = 1; jalr = 1; fwd_a = 2'b10; exmem_val = 32'h1001; r1 = 32'hDEAD_BEE0;
        imm = 32'd4; npc = 32'h200; npc4 = 32'h204; rd_in = 5'd1; cw_mem_in = 7'h05;
        step();
        check_eq("jalr_pc_sel", {31'd0, pc_sel}, 1);
        check_eq("jalr_jpc", jpc, 32'h1004);
        check_eq("jalr_npc4", npc4_out, 32'h204);
        check_eq("jalr_rd", {27'd0, rd_out}, 1);
        check_eq("jalr_cw", {25'd0, cw_mem}, 32'h05);

        // JAL with negative offset.
        clear_inputs();
        in_valid = 1; jal = 1; npc = 32'h300; imm = 32'hFFFF_FFF0;
        step();
        check_eq("jal_pc_sel", {31'd0, pc_sel}, 1);
        check_eq("jal_jpc", jpc, 32'h2F0);

        // ADD with fa from rf (code 11) and fb from MEM/WB.
        alu_instr(4'd0, 32'd10, 32'd99, 5'd3, 7'h11);
        fwd_a = 2'b11; fwd_b = 2'b01; memwb_val = 32'd5;
        step();
        check_eq("add_fwd_res", alu_res, 32'd15);
        check_eq("add_fwd_b_out", b_out, 32'd5);
        check_eq("add_fwd_cw", {25'd0, cw_mem}, 32'h11);
        check_eq("add_pc_sel", {31'd0, pc_sel}, 0);

        // SUB with immediate operand.
        alu_instr(4'd1, 32'd10, 32'd99, 5'd3, 7'h11);
        op_b_sel = 1; imm = 32'd3;
        step();
        check_eq("sub_imm_res", alu_res, 32'd7);

        // SRA and SLT.
        alu_instr(4'd7, 32'h8000_0000, 32'd4, 5'd3, 7'h11);
        step();
        check_eq("sra_res", alu_res, 32'hF800_0000);
        alu_instr(4'd3, 32'hFFFF_FFFF, 32'd1, 5'd3, 7'h11);
        step();
        check_eq("slt_res", alu_res, 32'd1);

        // ALU A from npc.
        alu_instr(4'd0, 32'd0, 32'd0, 5'd3, 7'h11);
        op_a_sel = 0; op_b_sel = 1; npc = 32'h1000; imm = 32'h10;
        step();
        check_eq("auipc_res", alu_res, 32'h1010);

        // Flushed taken branch loads a bubble.
        clear_inputs();
        in_valid = 1; flush = 1; br_type = 3'd1; rd_in = 5'd3; cw_mem_in = 7'h7F;
        step();
        check_eq("flush_pc_sel", {31'd0, pc_sel}, 0);
        check_eq("flush_cw", {25'd0, cw_mem}, 0);
        check_eq("flush_rd", {27'd0, rd_out}, 0);

        // Invalid slot loads a bubble.
        alu_instr(4'd0, 32'd1, 32'd1, 5'd4, 7'h22);
        in_valid = 0;
        step();
        check_eq("invalid_cw", {25'd0, cw_mem}, 0);

        // pipe_en=0 holds EX/MEM.
        alu_instr(4'd0, 32'd20, 32'd22, 5'd9, 7'h2A);
        step();
        pipe_en = 0;
        alu_instr(4'd0, 32'd1, 32'd2, 5'd1, 7'h01);
        step();
        check_eq("hold_res", alu_res, 32'd42);
        check_eq("hold_cw", {25'd0, cw_mem}, 32'h2A);
        check_eq("hold_rd", {27'd0, rd_out}, 9);
        pipe_en = 1;

`ifdef EXE_MULDIV_EN
        // Full-latency md operations.
        for (int i = 0; i < 15; i++) begin
            md_issue(md_tab[i].op, md_tab[i].a, md_tab[i].b);
            md_wait(n);
            check_eq($sformatf("md%0d_stall_cycles", i), n, 33);
            check_eq($sformatf("md%0d_bubble_cw", i), {25'd0, cw_mem}, 0);
            step();
            check_eq($sformatf("md%0d_res", i), alu_res, md_tab[i].res);
            check_eq($sformatf("md%0d_cw", i), {25'd0, cw_mem}, 32'h33);
            check_eq($sformatf("md%0d_pc_sel", i), {31'd0, pc_sel}, 0);
            clear_inputs();
        end

        // Flush at iteration 10.
        md_issue(3'd0, 32'd7, 32'd9);
        #1;
        repeat (11) step();
        check_eq("mdflush_busy", {31'd0, stall_o}, 1);
        flush = 1;
        step();
        clear_inputs();
        #1;
        check_eq("mdflush_stall", {31'd0, stall_o}, 0);
        check_eq("mdflush_cw", {25'd0, cw_mem}, 0);
        alu_instr(4'd0, 32'd3, 32'd4, 5'd2, 7'h11);
        #1;
        check_eq("post_flush_add_stall", {31'd0, stall_o}, 0);
        step();
        check_eq("post_flush_add_res", alu_res, 32'd7);
        check_eq("post_flush_add_cw", {25'd0, cw_mem}, 32'h11);

        // DONE held while pipe_en=0.
        md_issue(3'd5, 32'd100, 32'd7);
        md_wait(n);
        pipe_en = 0;
        repeat (3) step();
        check_eq("done_hold_stall", {31'd0, stall_o}, 0);
        check_eq("done_hold_cw", {25'd0, cw_mem}, 0);
        pipe_en = 1;
        step();
        check_eq("done_release_res", alu_res, 32'd14);
        check_eq("done_release_cw", {25'd0, cw_mem}, 32'h33);
        clear_inputs();

        // Asynchronous reset during BUSY.
        alu_instr(4'd0, 32'h11, 32'h22, 5'd4, 7'h15);
        npc = 32'h100; npc4 = 32'h104; imm = 32'h40;
        step();
        check_eq("pre_rst_res", alu_res, 32'h33);
        pipe_en = 0;
        md_issue(3'd0, 32'd3, 32'd5);
        repeat (5) step();
        #2 rst = 0;
        #1;
        check_eq("mdrst_res", alu_res, 0);
        check_eq("mdrst_cw", {25'd0, cw_mem}, 0);
        check_eq("mdrst_rd", {27'd0, rd_out}, 0);
        check_eq("mdrst_jpc", jpc, 0);
        check_eq("mdrst_npc4", npc4_out, 0);
        clear_inputs();
        #1;
        check_eq("mdrst_stall", {31'd0, stall_o}, 0);
        #1 rst = 1;
        pipe_en = 1;
        md_issue(3'd0, 32'd6, 32'd7);
        md_wait(n);
        check_eq("post_rst_md_stall_cycles", n, 33);
        step();
        check_eq("post_rst_md_res", alu_res, 32'd42);
        clear_inputs();
`else
        // Without the mul/div unit an md instruction is a plain ALU op.
        alu_instr(4'd0, 32'd7, 32'd3, 5'd6, 7'h19);
        md_en = 1; md_op = 3'd0;
        #1;
        check_eq("md_off_stall", {31'd0, stall_o}, 0);
        step();
        check_eq("md_off_res", alu_res, 32'd10);
        check_eq("md_off_cw", {25'd0, cw_mem}, 32'h19);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
